// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: common counter
// resolution, capture FSM states and the capture debug view.
package pwm_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } cap_state_t;

   typedef struct packed {
      cap_state_t state;
      logic       sync;
      logic       rise;
      logic       fall;
   } cap_dbg_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its user.
// valid is a one-cycle strobe with no ready/backpressure: duty and period are
// meaningful only in the cycle valid=1 and hold afterwards until the next strobe.
interface pwm_capture_if #(
   parameter int CNT_W = pwm_pkg::CNT_W_DEFAULT
);
   logic             enable;
   logic             pwm_in;
   logic [CNT_W-1:0] duty;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             stuck;

   modport master (
      output enable, pwm_in,
      input  duty, period, valid, stuck
   );

   modport slave (
      input  enable, pwm_in,
      output duty, period, valid, stuck
   );
endinterface

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a delay flop,
// giving the synchronized level and single-cycle rise/fall pulses.
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[STAGES-2:0], d};
         prev <= sr[STAGES-1];
      end
   end

   assign sync = sr[STAGES-1];
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// producing one duty/period result per rising-edge-to-rising-edge period.
module pwm_capture import pwm_pkg::*; #(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   pwm_capture_if.slave ifc,
   output cap_dbg_t     dbg
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   cap_state_t       state, state_nx;
   logic             sync, rise, fall;
   logic [CNT_W-1:0] hi_cnt, per_cnt;
   logic [CNT_W-1:0] duty, period;
   logic             valid, stuck;
   logic             cnt_clr, cnt_load, cnt_inc, emit, sat;

   edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (ifc.pwm_in),
      .sync (sync),
      .rise (rise),
      .fall (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Disable beats everything, including a rise in the same cycle.
   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      emit     = 1'b0;
      sat      = 1'b0;
      if (!ifc.enable) begin
         state_nx = IDLE;
         cnt_clr  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nx = ARM;
               cnt_clr  = 1'b1;
            end
            ARM: begin
               if (rise) begin
                  state_nx = MEAS;
                  cnt_load = 1'b1;
               end else begin
                  cnt_clr = 1'b1;
               end
            end
            MEAS: begin
               if (rise) begin
                  emit     = 1'b1;
                  cnt_load = 1'b1;
               end else if (per_cnt == CNT_MAX) begin
                  sat      = 1'b1;
                  state_nx = ARM;
                  cnt_clr  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_clr  = 1'b1;
            end
         endcase
      end
   end

   // The cycle carrying the rise is the first cycle of the new period.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         hi_cnt  <= '0;
         per_cnt <= '0;
      end else if (cnt_load) begin
         hi_cnt  <= CNT_ONE;
         per_cnt <= CNT_ONE;
      end else if (cnt_inc) begin
         hi_cnt  <= hi_cnt + {{(CNT_W-1){1'b0}}, sync};
         per_cnt <= per_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty   <= '0;
         period <= '0;
         valid  <= 1'b0;
         stuck  <= 1'b0;
      end else begin
         valid <= emit;
         if (emit) begin
            duty   <= hi_cnt;
            period <= per_cnt;
            stuck  <= 1'b0;
         end else if (sat) begin
            stuck <= 1'b1;
         end
      end
   end

   assign ifc.duty   = duty;
   assign ifc.period = period;
   assign ifc.valid  = valid;
   assign ifc.stuck  = stuck;
   assign dbg        = '{state: state, sync: sync, rise: rise, fall: fall};
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: square-wave table, duty step, enable abort, reset,
// saturation on a 4-bit instance and a randomized stream against a period model.
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int W  = 16;
   localparam int W4 = 4;
   localparam int SS = 2;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_duty;
      int exp_period;
   } row_t;

   typedef struct {
      int duty;
      int period;
      int cyc;
   } exp_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   int       cyc = 0;
   int       checks = 0;
   int       fails = 0;
   cap_dbg_t dbg16, dbg4;

   // model state: the period currently being driven, closed by the next rise
   exp_t     exp_q[$];
   int       have_prev = 0;
   int       prev_hi = 0;
   int       prev_lo = 0;
   int       vcount = 0;
   int       v4count = 0;
   int       v4_duty = 0;
   int       v4_period = 0;
   int       v4_stuck = 0;

   row_t     rows[6];

   pwm_capture_if #(.CNT_W(W))  if16 ();
   pwm_capture_if #(.CNT_W(W4)) if4 ();

   pwm_capture #(.CNT_W(W), .SYNC_STAGES(SS)) dut16 (
      .clk (clk),
      .rst (rst),
      .ifc (if16.slave),
      .dbg (dbg16)
   );

   pwm_capture #(.CNT_W(W4), .SYNC_STAGES(SS)) dut4 (
      .clk (clk),
      .rst (rst),
      .ifc (if4.slave),
      .dbg (dbg4)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks: entered and left at a negedge
   task automatic rise_edge(input int hi, input int lo);
      exp_t e;
      if16.pwm_in = 1'b1;
      if (have_prev != 0) begin
         e.duty   = prev_hi;
         e.period = prev_hi + prev_lo;
         e.cyc    = cyc + 1 + SS;
         exp_q.push_back(e);
      end
      have_prev = 1;
      prev_hi   = hi;
      prev_lo   = lo;
   endtask

   task automatic drive_period(input int hi, input int lo);
      rise_edge(hi, lo);
      repeat (hi) @(negedge clk);
      if16.pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic idle_low(input int n);
      if16.pwm_in = 1'b0;
      if (have_prev != 0) prev_lo += n;
      repeat (n) @(negedge clk);
   endtask

   task automatic restart_stream();
      if16.enable = 1'b0;
      have_prev   = 0;
      repeat (3) @(negedge clk);
      if16.enable = 1'b1;
      idle_low(4);
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (if16.valid) begin
         vcount++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid: duty=%0d period=%0d at cycle %0d, expected no valid",
                     if16.duty, if16.period, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("duty", if16.duty, e.duty);
            check("period", if16.period, e.period);
            check("valid_cycle", cyc, e.cyc);
            check("stuck_on_valid", if16.stuck, 0);
         end
      end
      if (if4.valid) begin
         v4count++;
         v4_duty   = if4.duty;
         v4_period = if4.period;
         v4_stuck  = if4.stuck;
      end
   end

   initial begin
      int base;
      int n;

      rows[0] = '{3, 5, 5, 3, 8};
      rows[1] = '{1, 1, 6, 1, 2};
      rows[2] = '{10, 10, 3, 10, 20};
      rows[3] = '{1, 7, 3, 1, 8};
      rows[4] = '{7, 1, 3, 7, 8};
      rows[5] = '{12, 3, 4, 12, 15};

      if16.enable = 1'b0;
      if16.pwm_in = 1'b0;
      if4.enable  = 1'b0;
      if4.pwm_in  = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_duty", if16.duty, 0);
      check("rst_period", if16.period, 0);
      check("rst_valid", if16.valid, 0);
      check("rst_stuck", if16.stuck, 0);
      check("rst_state", dbg16.state, IDLE);
      check("rst_state4", dbg4.state, IDLE);
      rst = 1'b0;
      @(negedge clk);

      // table of square waves, each from a fresh enable
      for (int r = 0; r < 6; r++) begin
         restart_stream();
         base = vcount;
         repeat (rows[r].reps) drive_period(rows[r].hi, rows[r].lo);
         idle_low(6);
         check("row_duty", if16.duty, rows[r].exp_duty);
         check("row_period", if16.period, rows[r].exp_period);
         check("row_valids", vcount - base, rows[r].reps - 1);
      end

      // duty step 10/20 -> 15/20 without a break in the stream
      restart_stream();
      base = vcount;
      repeat (3) drive_period(10, 10);
      repeat (3) drive_period(15, 5);
      idle_low(6);
      check("step_valids", vcount - base, 5);
      check("step_duty", if16.duty, 15);

      // enable dropped mid-period, then re-enabled while input is high
      restart_stream();
      repeat (3) drive_period(4, 4);
      rise_edge(0, 0);
      repeat (4) @(negedge clk);
      base = vcount;
      if16.enable = 1'b0;
      have_prev   = 0;
      repeat (2) @(negedge clk);
      check("abort_state", dbg16.state, IDLE);
      if16.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      if16.pwm_in = 1'b1;
      repeat (4) @(negedge clk);
      check("hold_duty", if16.duty, 4);
      check("hold_period", if16.period, 8);
      check("abort_valids", vcount - base, 0);
      if16.enable = 1'b1;
      repeat (2) @(negedge clk);
      check("partial_arm_state", dbg16.state, ARM);
      idle_low(3);
      repeat (3) drive_period(6, 2);
      check("reenable_valids", vcount - base, 2);
      check("pre_rst_state", dbg16.state, MEAS);

      // one-cycle reset while measuring
      rst = 1'b1;
      have_prev = 0;
      @(negedge clk);
      check("mrst_duty", if16.duty, 0);
      check("mrst_period", if16.period, 0);
      check("mrst_valid", if16.valid, 0);
      check("mrst_state", dbg16.state, IDLE);
      rst = 1'b0;

      // randomized stream
      idle_low(4);
      repeat (40) drive_period($urandom_range(1, 12), $urandom_range(1, 12));
      idle_low(6);

      // saturation on the 4-bit instance: held high after one rise
      if4.enable = 1'b1;
      if4.pwm_in = 1'b0;
      repeat (4) @(negedge clk);
      base = v4count;
      if4.pwm_in = 1'b1;
      n = cyc + 1;
      for (int i = 0; i < 40 && if4.stuck !== 1'b1; i++) @(negedge clk);
      check("stuck_high_set", if4.stuck, 1);
      check("stuck_high_cycle", cyc, n + 17);
      check("stuck_state", dbg4.state, ARM);
      repeat (5) @(negedge clk);
      check("stuck_sticky", if4.stuck, 1);
      check("stuck_no_valid", v4count - base, 0);
      if4.pwm_in = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if4.pwm_in = 1'b1;
         repeat (2) @(negedge clk);
         if4.pwm_in = 1'b0;
         repeat (2) @(negedge clk);
         if (k == 0) check("stuck_before_valid", if4.stuck, 1);
      end
      repeat (4) @(negedge clk);
      check("w4_valids", v4count - base, 2);
      check("w4_duty", v4_duty, 2);
      check("w4_period", v4_period, 4);
      check("w4_stuck_cleared", v4_stuck, 0);
      check("w4_stuck_now", if4.stuck, 0);

      // constant low also saturates
      for (int i = 0; i < 40 && if4.stuck !== 1'b1; i++) @(negedge clk);
      check("stuck_low_set", if4.stuck, 1);
      check("stuck_low_no_valid", v4count - base, 2);

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart to the PWM generator: samples an incoming PWM waveform and measures its high time and period in `Clk` cycles. Each completed period (rising edge to rising edge) produces one Duty/Period result with a single-cycle `Valid` strobe. Used in the ANC loopback path to verify the generator output and to decode externally modulated duty values.

## Interface
- `CNT_W`, 16: width of the high-time and period counters and outputs.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer, minimum 2.

- `Clk`  in  1  single system clock; all logic on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Enable`  in  1  capture enable; low forces IDLE.
- `Pwm_in`  in  1  asynchronous PWM input.
- `Duty`  out  CNT_W  high-time of the last complete period, in cycles.
- `Period`  out  CNT_W  length of the last complete period, in cycles.
- `Valid`  out  1  one-cycle pulse when `Duty`/`Period` update.
- `Stuck`  out  1  period counter saturated with no rising edge; sticky until the next `Valid`.

## Operation
- Synchronizer: `SYNC_STAGES` flops, then one delay flop `prev`. `rise = sync & ~prev`.
- FSM states:
  - IDLE: counters held at 0; go to ARM when `Enable`=1.
  - ARM: wait for `rise`, which discards the first partial period; go to MEAS on `rise`.
  - MEAS: measure the period.
- Any state goes to IDLE when `Enable`=0. Results in flight are discarded; `Duty`, `Period` and `Stuck` hold their values.
- Counters in MEAS:
  - On the entry `rise`: `hi_cnt`=1, `per_cnt`=1.
  - On every later cycle: `per_cnt`+1, and `hi_cnt`+1 while `sync`=1.
- Next `rise` while in MEAS:
  - `Duty`<=`hi_cnt`, `Period`<=`per_cnt`, using pre-increment values.
  - `Valid`=1 and `Stuck`<=0.
  - Counters restart at 1 and the FSM stays in MEAS.
- Saturation:
  - Trigger: `per_cnt` = 2^CNT_W−1 and no `rise` in that cycle.
  - Response: `Stuck`<=1, no `Valid`, FSM goes to ARM.
  - This covers both a constant-high and a constant-low input.
- Arithmetic: unsigned, with `Duty` ≤ `Period` always. Constant-high within a period gives `Duty` = `Period` − (low cycles). The minimum measurable period is 2 (1 high, 1 low).
- Glitches shorter than one `Clk` period are not filtered. Any synchronized pulse counts.

## Timing
- Reset values: `Duty`=0, `Period`=0, `Valid`=0, `Stuck`=0, FSM=IDLE, synchronizer and `prev`=0.
- Latency: a `Pwm_in` rising edge causes `Valid` SYNC_STAGES+1 cycles later (±1 for asynchronous sampling).
- `Valid` is exactly 1 cycle wide. It is registered together with `Duty` and `Period`, so all three change in the same cycle.
- Throughput: one result per input period, with no dead cycles between consecutive periods.
- `Rst` has priority over `Enable`. `Rst` during MEAS clears everything within the same cycle edge.
- `Enable` rising: the first `Valid` arrives no earlier than the second synchronized rising edge after enable.
- `Enable` falling and `rise` in the same cycle: `Enable` wins, and no `Valid` is produced.

## Structure
- Package `pwm_pkg`:
  - state enum `cap_state_t` {IDLE, ARM, MEAS};
  - default `CNT_W` constant, shared with the PWM generator so both ends use the same resolution.
- Sub-module `edge_sync`: parameterised synchronizer plus `prev` flop. Outputs `sync`, `rise` and `fall`; `fall` is unused here and kept for reuse.
- Top level: FSM, two counters, output registers.

## Test plan
- Square wave, 3 cycles high / 5 low, Enable=1 from reset release:
  - first `Valid` only after the second rise;
  - `Duty`=3, `Period`=8 on every subsequent `Valid`, spaced 8 cycles apart.
- Duty step from 10/20 to 15/20 mid-stream:
  - one `Valid` with 10/20, then the next with 15/20;
  - no intermediate values.
- Minimum period 1 high / 1 low → `Duty`=1, `Period`=2, with `Valid` every other cycle.
- `CNT_W`=4 with `Pwm_in` held high after one rise:
  - `Stuck`=1 after 15 cycles, no `Valid`;
  - restoring a 2/4 wave clears `Stuck` on the next `Valid` (`Duty`=2, `Period`=4).
- `Enable` deasserted mid-period, then reasserted:
  - no `Valid` for the aborted period;
  - outputs hold their old values;
  - ARM discards the first partial period.
- `Rst` pulsed for 1 cycle during MEAS → all outputs are 0 the next cycle and FSM=IDLE.
